coil_seq_dsm: RTL and testbench
===============================

# coil_seq_dsm

Parametrised multi-phase coil sequencer with delta-sigma amplitude modulation. It generalises the fixed six-phase LED/coil driver to N channels, a run-time step rate, direction control and an enable. A prescaled tick steps a phase index around NCH channels. A first-order delta-sigma modulator gates the active channel with a pulse density proportional to `amp`. It sits at top level, driving the coil/PMOD pins directly from `clk`.

## Interface
- `NCH`, 6: number of channels/phases (2..32)
- `PRESC`, 61035: `clk` cycles per tick (≥2)
- `AMP_W`, 10: amplitude and modulator accumulator width
- `STEP_W`, 16: width of `step_div`
- `clk`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `en`  in  1  run enable
- `dir`  in  1  0 = phase increments, 1 = phase decrements
- `step_div`  in  STEP_W  ticks per phase step; 0 treated as 1
- `amp`  in  AMP_W  modulation level; density = amp / 2^AMP_W
- `coil`  out  NCH  gated one-hot channel drive
- `phase`  out  $clog2(NCH)  current phase index
- `step_stb`  out  1  one-cycle pulse on each phase advance

## Operation
- Reset (`rst_n`=0 at an edge) zeroes: prescaler, tick counter, `phase`, accumulator, `coil`, `step_stb`. This is the value of every output the cycle after reset, including mid-operation.
- Prescaler: counts 0..PRESC-1 while `en`=1; `tick` is asserted internally on the cycle the count equals PRESC-1, then the count wraps to 0.
- Step counter: on `tick`, if cnt ≥ max(step_div,1)-1, then cnt←0 and phase advances; else cnt←cnt+1. The ≥ compare means a shrink of `step_div` mid-count advances on the next tick.
- Phase advance: `dir`=0 gives NCH-1→0 wrap; `dir`=1 gives 0→NCH-1 wrap. `step_stb`=1 for exactly that cycle.
- Modulator: sum = {0,acc}+{0,amp_eff}; acc←sum[AMP_W-1:0]; carry = sum[AMP_W].
- Output: `coil` ← carry ? (1<<phase) : 0, registered. At most one bit of `coil` is ever set.
- `en`=0 has priority over everything except reset:
  - prescaler, step counter and `phase` hold;
  - acc←0;
  - `coil`←0;
  - `step_stb`←0.
- `amp`=0 never pulses. `amp`=2^AMP_W-1 pulses all but 1 of every 2^AMP_W cycles.

## Timing
- `amp` or `phase` change to `coil` effect: 1 cycle (registered output).
- First carry after reset/enable with amp=2^(AMP_W-1): second enabled cycle, then alternating.
- Step period = PRESC·max(step_div,1) cycles. `step_stb` and the new `phase` appear in the same cycle. `coil` reflects the new phase one cycle later.
- `en` falling: `coil` is 0 from the next cycle. `en` rising: the prescaler resumes from its held count.

## Configuration
- `COIL_SEQ_RAMP_EN` defined: `amp_eff` is a register, reset to 0. On each `tick` it slews ±1 LSB toward `amp`, and holds when equal. `en`=0 forces `amp_eff`←0.
- Not defined: `amp_eff` = `amp`, with no ramp register.

## Structure
- Package `coil_seq_pkg`: default parameter constants (`NCH_DEF`, `PRESC_DEF`, `AMP_W_DEF`) and a `dir_e` enum (DIR_FWD=0, DIR_REV=1).
- One sub-module `dsm1` (first-order delta-sigma):
  - ports `clk`, `rst_n`, `clr`, `din[AMP_W]`, `pulse`;
  - `clr`=en inverted;
  - `pulse` is the combinational carry.
- The sequencer, prescaler, ramp and output register live in the top.

## Test plan
(PRESC=4, NCH=6, AMP_W=4 unless noted)
- Reset mid-run, with `rst_n` low for 1 cycle during phase 3 and `coil`≠0 → next cycle: `phase`=0, `coil`=0, `step_stb`=0.
- en=1, dir=0, step_div=2, amp=15:
  - `step_stb` every 8 cycles;
  - phase 0,1,…,5,0;
  - `coil` one-hot, matching phase and lagging it by 1 cycle.
- dir=1 from phase 0, step_div=1 → phase 5,4,3 at 4-cycle spacing.
- amp=8 → `coil` bit pattern 0,1,0,1… (first pulse on 2nd enabled cycle). amp=0 → `coil` stays 0 for 100 cycles.
- step_div 0 vs 1 produce identical traces. Change step_div 5→1 when cnt=3 → advance at the next tick.
- With `COIL_SEQ_RAMP_EN`, amp step 0→3 → amp_eff 1,2,3 on successive ticks. Drop `en` → `coil`=0 next cycle, and `phase` held.

Source files
------------

// File: rtl/coil_seq_pkg.sv
// Shared constants and types for the coil_seq_dsm multi-phase coil sequencer.
package coil_seq_pkg;

    localparam int unsigned NCH_DEF    = 6;
    localparam int unsigned PRESC_DEF  = 61035;
    localparam int unsigned AMP_W_DEF  = 10;
    localparam int unsigned STEP_W_DEF = 16;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Width of an index able to address n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coil_seq_dsm_if.sv
// Control and drive bundle of the coil sequencer: run controls in, coil drive out.
interface coil_seq_dsm_if #(
    parameter int unsigned NCH    = 6,
    parameter int unsigned AMP_W  = 10,
    parameter int unsigned STEP_W = 16
);
    localparam int unsigned PH_W = $clog2(NCH);

    logic              en;
    logic              dir;
    logic [STEP_W-1:0] step_div;
    logic [AMP_W-1:0]  amp;
    logic [NCH-1:0]    coil;
    logic [PH_W-1:0]   phase;
    logic              step_stb;

    modport master (
        output en, dir, step_div, amp,
        input  coil, phase, step_stb
    );

    modport slave (
        input  en, dir, step_div, amp,
        output coil, phase, step_stb
    );

endinterface

// File: rtl/coil_seq_dsm_dsm1.sv
// First-order delta-sigma modulator: pulse density on carry equals din / 2^AMP_W.
module dsm1 #(
    parameter int unsigned AMP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [AMP_W-1:0] din,
    output logic             pulse
);

    logic [AMP_W-1:0] acc;
    logic [AMP_W:0]   sum_c;

    // Carry out of the accumulator is the modulated pulse, offered combinationally.
    always_comb begin
        sum_c = {1'b0, acc} + {1'b0, din};
        pulse = sum_c[AMP_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else begin
            acc <= sum_c[AMP_W-1:0];
        end
    end

endmodule

// File: rtl/coil_seq_dsm.sv
// N-phase coil sequencer with prescaled stepping and delta-sigma amplitude gating.
// Optional COIL_SEQ_RAMP_EN: amplitude slews one LSB per tick toward amp.
module coil_seq_dsm
    import coil_seq_pkg::*;
#(
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned PRESC  = PRESC_DEF,
    parameter int unsigned AMP_W  = AMP_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    coil_seq_dsm_if.slave bus
);

    localparam int unsigned PH_W  = $clog2(NCH);
    localparam int unsigned PRE_W = idx_w(PRESC);

    logic [PRE_W-1:0]  pre_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [PH_W-1:0]   phase_q;
    logic [NCH-1:0]    coil_q;
    logic              stb_q;

    logic              tick_c;
    logic              adv_c;
    logic [STEP_W-1:0] div_m1_c;
    logic [PH_W-1:0]   phase_nxt_c;
    logic [AMP_W-1:0]  amp_eff;
    logic              pulse;

    // Tick on the last prescaler count; a zero divider behaves like one.
    always_comb begin
        tick_c   = bus.en && (pre_cnt == PRE_W'(PRESC - 1));
        div_m1_c = (bus.step_div == '0) ? '0 : (bus.step_div - STEP_W'(1));
        adv_c    = tick_c && (step_cnt >= div_m1_c);
    end

    // Next phase index with wrap in either direction.
    always_comb begin
        phase_nxt_c = phase_q;
        if (dir_e'(bus.dir) == DIR_REV) begin
            phase_nxt_c = (phase_q == '0) ? PH_W'(NCH - 1) : (phase_q - PH_W'(1));
        end else begin
            phase_nxt_c = (phase_q == PH_W'(NCH - 1)) ? '0 : (phase_q + PH_W'(1));
        end
    end

    // Prescaler, step counter and phase freeze while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
            phase_q  <= '0;
        end else if (bus.en) begin
            pre_cnt <= tick_c ? '0 : (pre_cnt + PRE_W'(1));
            if (tick_c) begin
                step_cnt <= adv_c ? '0 : (step_cnt + STEP_W'(1));
            end
            if (adv_c) begin
                phase_q <= phase_nxt_c;
            end
        end
    end

`ifdef COIL_SEQ_RAMP_EN
    // Amplitude ramps toward the request one LSB per tick, restarting from 0 when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            amp_eff <= '0;
        end else if (!bus.en) begin
            amp_eff <= '0;
        end else if (tick_c) begin
            if (amp_eff < bus.amp) begin
                amp_eff <= amp_eff + AMP_W'(1);
            end else if (amp_eff > bus.amp) begin
                amp_eff <= amp_eff - AMP_W'(1);
            end
        end
    end
`else
    always_comb begin
        amp_eff = bus.amp;
    end
`endif

    dsm1 #(
        .AMP_W (AMP_W)
    ) u_dsm1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.en),
        .din   (amp_eff),
        .pulse (pulse)
    );

    // Registered gated drive; the coil follows the phase held at the sampling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coil_q <= '0;
            stb_q  <= 1'b0;
        end else if (!bus.en) begin
            coil_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            coil_q <= pulse ? (NCH'(1) << phase_q) : '0;
            stb_q  <= adv_c;
        end
    end

    assign bus.coil     = coil_q;
    assign bus.phase    = phase_q;
    assign bus.step_stb = stb_q;

endmodule

// File: tb/tb_coil_seq_dsm.sv
// Directed and randomized bench for coil_seq_dsm (NCH=6, PRESC=4, AMP_W=4) against a cycle model.
module tb_coil_seq_dsm;
    import coil_seq_pkg::*;

    localparam int NCH    = 6;
    localparam int PRESC  = 4;
    localparam int AMP_W  = 4;
    localparam int STEP_W = 16;
    localparam int AMOD   = 2 ** AMP_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    coil_seq_dsm_if #(.NCH(NCH), .AMP_W(AMP_W), .STEP_W(STEP_W)) bus ();

    coil_seq_dsm #(
        .NCH    (NCH),
        .PRESC  (PRESC),
        .AMP_W  (AMP_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, as the specification describes it.
    int m_pre, m_cnt, m_phase, m_acc, m_coil, m_stb, m_ampeff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int amp_now, sum, d;
        bit tick;
        if (!rst_n) begin
            m_pre = 0; m_cnt = 0; m_phase = 0; m_acc = 0;
            m_coil = 0; m_stb = 0; m_ampeff = 0;
        end else if (!bus.en) begin
            m_acc = 0; m_coil = 0; m_stb = 0; m_ampeff = 0;
        end else begin
`ifdef COIL_SEQ_RAMP_EN
            amp_now = m_ampeff;
`else
            amp_now = int'(bus.amp);
`endif
            tick   = (m_pre == PRESC - 1);
            sum    = m_acc + amp_now;
            m_coil = (sum >= AMOD) ? (1 << m_phase) : 0;
            m_acc  = sum % AMOD;
            m_pre  = tick ? 0 : m_pre + 1;
            m_stb  = 0;
            if (tick) begin
                d = (bus.step_div == 0) ? 1 : int'(bus.step_div);
                if (m_cnt >= d - 1) begin
                    m_cnt   = 0;
                    m_stb   = 1;
                    m_phase = bus.dir ? (m_phase + NCH - 1) % NCH : (m_phase + 1) % NCH;
                end else begin
                    m_cnt++;
                end
                if (m_ampeff < int'(bus.amp)) m_ampeff++;
                else if (m_ampeff > int'(bus.amp)) m_ampeff--;
            end
        end
    endtask

    // One clock: advance the model with the applied inputs, then compare after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("phase", 32'(bus.phase), 32'(m_phase));
        chk("coil", 32'(bus.coil), 32'(m_coil));
        chk("step_stb", 32'(bus.step_stb), 32'(m_stb));
        chk("coil_onehot", 32'($countones(bus.coil) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, gap, held, idx, k, found;
        int exp_rev[3];

        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.dir = DIR_FWD;
        bus.step_div = '0;
        bus.amp = '0;
        #1;
        do_reset();
        chk("reset_phase", 32'(bus.phase), 32'd0);
        chk("reset_coil", 32'(bus.coil), 32'd0);
        chk("reset_stb", 32'(bus.step_stb), 32'd0);

        // Forward stepping, step_div=2, full amplitude.
        bus.en = 1'b1; bus.dir = DIR_FWD; bus.step_div = 16'd2; bus.amp = 4'd15;
        last = -1;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (bus.step_stb === 1'b1) begin
                if (last >= 0) chk("stb_period_div2", 32'(c - last), 32'd8);
                last = c;
            end
        end

        // Reset pulse mid-run while in phase 3 with a live coil.
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cycle();
            if (m_phase == 3 && bus.coil !== '0) found = 1;
        end
        chk("reach_phase3", 32'(found), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_phase", 32'(bus.phase), 32'd0);
        chk("midrst_coil", 32'(bus.coil), 32'd0);
        chk("midrst_stb", 32'(bus.step_stb), 32'd0);

        // Reverse stepping from phase 0 with step_div=1.
        bus.dir = DIR_REV; bus.step_div = 16'd1;
        exp_rev[0] = 5; exp_rev[1] = 4; exp_rev[2] = 3;
        idx = 0; last = -1;
        for (int c = 0; c < 13; c++) begin
            cycle();
            if (bus.step_stb === 1'b1 && idx < 3) begin
                chk("rev_phase", 32'(bus.phase), 32'(exp_rev[idx]));
                if (last >= 0) chk("rev_period", 32'(c - last), 32'd4);
                last = c;
                idx++;
            end
        end
        chk("rev_steps_seen", 32'(idx), 32'd3);

        // Half amplitude: 0,1,0,1 on bit 0 from a clean start.
        do_reset();
        bus.en = 1'b1; bus.dir = DIR_FWD; bus.step_div = 16'd100; bus.amp = 4'd8;
        for (int c = 1; c <= 8; c++) begin
            cycle();
`ifndef COIL_SEQ_RAMP_EN
            chk("half_amp_pattern", 32'(bus.coil), (c % 2 == 0) ? 32'd1 : 32'd0);
`endif
        end

        // Zero amplitude never pulses.
        bus.amp = 4'd0;
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (c >= 2) chk("amp0_quiet", 32'(bus.coil), 32'd0);
        end

        // step_div=0 behaves as 1.
        bus.amp = 4'd11; bus.step_div = 16'd0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (bus.step_stb === 1'b1) begin
                if (last >= 0) chk("stb_period_div0", 32'(c - last), 32'd4);
                last = c;
            end
        end

        // Shrinking step_div 5->1 at count 3 advances on the next tick.
        bus.step_div = 16'd5;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            cycle();
            if (m_cnt == 3 && m_pre == 0) found = 1;
        end
        chk("reach_cnt3", 32'(found), 32'd1);
        bus.step_div = 16'd1;
        k = -1;
        for (int c = 0; c < PRESC; c++) begin
            cycle();
            if (bus.step_stb === 1'b1 && k < 0) k = c;
        end
        chk("shrink_adv_cycle", 32'(k), 32'(PRESC - 1));

        // Dropping en clears the coil next cycle and holds the phase.
        bus.amp = 4'd15;
        for (int c = 0; c < 7; c++) cycle();
        held = m_phase;
        bus.en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("dis_coil", 32'(bus.coil), 32'd0);
            chk("dis_phase_hold", 32'(bus.phase), 32'(held));
        end
        bus.en = 1'b1;
        for (int c = 0; c < 20; c++) cycle();

`ifdef COIL_SEQ_RAMP_EN
        // Ramp from 0 toward 3 one LSB per tick.
        do_reset();
        bus.en = 1'b1; bus.amp = 4'd3; bus.step_div = 16'd50;
        for (int t = 1; t <= 5; t++) begin
            for (int c = 0; c < PRESC; c++) cycle();
            chk("ramp_amp_eff", 32'(dut.amp_eff), 32'((t < 3) ? t : 3));
        end
`endif

        // Randomized segments with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.en       = ($urandom_range(0, 5) != 0);
                bus.dir      = 1'($urandom_range(0, 1));
                bus.step_div = 16'($urandom_range(0, 3));
                bus.amp      = 4'($urandom_range(0, 15));
            end
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
